// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
// Request layout, producer count and small helpers used by picker and top.
package wb_port_arbiter_pkg;

    localparam int WB_REQ_N  = 4;
    localparam int WB_WIDTH  = 32;
    localparam int WB_ADDR_W = 6;
    localparam int WB_CNT_W  = 16;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_WIDTH-1:0]  data;
    } wb_req_t;

    localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

    function automatic logic [WB_REQ_N-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // True when at least two bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_valid(input logic [WB_REQ_N-1:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick4.sv
// Round-robin picker: first valid producer searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Purely combinational; any=0 when nothing is valid (g then reads as ptr).
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] g
);

    logic [1:0] idx;

    // Walk the search order backwards so the earliest valid entry is the last to write g.
    always_comb begin
        any = 1'b0;
        g   = ptr;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (valid[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates four result producers onto the single register-file write port.
// One-cycle accept-to-write latency; stall withholds every grant and holds ptr.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [WB_REQ_N-1:0]               req_valid,
    input  logic [WB_REQ_N-1:0][ADDR_W-1:0]   req_addr,
    input  logic [WB_REQ_N-1:0][WIDTH-1:0]    req_data,
    output logic [WB_REQ_N-1:0]               req_ready,
    input  logic                              stall,
    output logic                              wb_en,
    output logic [ADDR_W-1:0]                 wb_addr,
    output logic [WIDTH-1:0]                  wb_data,
    output logic [1:0]                        wb_src,
    output logic [CNT_W-1:0]                  conflict_cnt
);

    logic              any;
    logic [1:0]        g;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    logic [1:0]        ptr_q,     ptr_d;
    logic              wb_en_q,   wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic [1:0]        wb_src_q,  wb_src_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    rr_pick4 u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .any   (any),
        .g     (g)
    );

    // Ready is gated by rstn so no grant escapes while the block is held in reset.
    assign xfer      = any & ~stall & rstn;
    assign req_ready = xfer ? onehot4(g) : '0;

    always_comb begin
        sel_addr = req_addr[0];
        case (g)
            2'd0:    sel_addr = req_addr[0];
            2'd1:    sel_addr = req_addr[1];
            2'd2:    sel_addr = req_addr[2];
            default: sel_addr = req_addr[3];
        endcase
    end

    always_comb begin
        sel_data = req_data[0];
        case (g)
            2'd0:    sel_data = req_data[0];
            2'd1:    sel_data = req_data[1];
            2'd2:    sel_data = req_data[2];
            default: sel_data = req_data[3];
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_src_d  = wb_src_q;
        if (xfer) begin
            // Writes to register 0 are consumed but never reach the file.
            wb_en_d   = (sel_addr != ADDR_W'(ZERO_REG));
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
            wb_src_d  = g;
            ptr_d     = g + 2'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!stall && multi_valid(req_valid) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_src_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_src_q  <= wb_src_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_src       = wb_src_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic             clk = 1'b0;
    logic             rstn;
    logic [3:0]       req_valid;
    logic [3:0][5:0]  req_addr;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic             stall;
    logic             wb_en;
    logic [5:0]       wb_addr;
    logic [31:0]      wb_data;
    logic [1:0]       wb_src;
    logic [15:0]      conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_src       (wb_src),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        stall     = 1'b0;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 6'(10 + i);
            req_data[i] = 32'h100 + 32'(i);
        end
        #12;
        check("rst_ready",   32'(req_ready),    32'h0);
        check("rst_wb_en",   32'(wb_en),        32'h0);
        check("rst_wb_addr", 32'(wb_addr),      32'h0);
        check("rst_wb_data", wb_data,           32'h0);
        check("rst_wb_src",  32'(wb_src),       32'h0);
        check("rst_cnt",     32'(conflict_cnt), 32'h0);
        rstn = 1'b1;
        tick();

        // Single producer 1 from ptr=0.
        req_addr[1]  = 6'd5;
        req_data[1]  = 32'hDEADBEEF;
        req_valid    = 4'b0010;
        #1 check("t1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("t1_wb_en",   32'(wb_en),   32'h1);
        check("t1_wb_addr", 32'(wb_addr), 32'h5);
        check("t1_wb_data", wb_data,      32'hDEADBEEF);
        check("t1_wb_src",  32'(wb_src),  32'h1);
        // ptr=2 makes producer 2 win over producer 1.
        req_valid = 4'b0110;
        #1 check("t1_ptr_probe", 32'(req_ready), 32'h4);
        req_valid = 4'b0000;
        tick();
        check("idle_wb_en",   32'(wb_en),   32'h0);
        check("idle_wb_addr", 32'(wb_addr), 32'h5);

        // All four valid from reset.
        rstn = 1'b0;
        #1 rstn = 1'b1;
        req_valid = 4'b1111;
        #1 check("t2_first_wb_en", 32'(wb_en), 32'h0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("t2_wb_en%0d", k),  32'(wb_en),  32'h1);
            check($sformatf("t2_wb_src%0d", k), 32'(wb_src), 32'(k % 4));
        end
        check("t2_wb_data", wb_data, 32'h100);
        check("t2_cnt", 32'(conflict_cnt), 32'd5);

        // ptr=1 with producers 0 and 2.
        req_valid = 4'b0101;
        #1 check("t3_ready_a", 32'(req_ready), 32'h4);
        tick();
        check("t3_src_a", 32'(wb_src), 32'h2);
        req_valid = 4'b0001;
        #1 check("t3_ready_b", 32'(req_ready), 32'h1);
        tick();
        check("t3_src_b", 32'(wb_src), 32'h0);
        check("t3_cnt", 32'(conflict_cnt), 32'd6);

        // Stall with producers 3 and 0 pending, ptr=1.
        stall     = 1'b1;
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("t4_stall_ready%0d", k), 32'(req_ready), 32'h0);
            tick();
            check($sformatf("t4_stall_wb_en%0d", k), 32'(wb_en), 32'h0);
        end
        check("t4_stall_cnt", 32'(conflict_cnt), 32'd6);
        stall = 1'b0;
        #1 check("t4_release_ready", 32'(req_ready), 32'h8);
        tick();
        check("t4_src",   32'(wb_src),       32'h3);
        check("t4_wb_en", 32'(wb_en),        32'h1);
        check("t4_cnt",   32'(conflict_cnt), 32'd7);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;

        // Register 0 destination is consumed without a write.
        req_addr[2] = 6'd0;
        req_data[2] = 32'h1234;
        req_valid   = 4'b0100;
        #1 check("t5_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        check("t5_wb_en", 32'(wb_en),  32'h0);
        check("t5_src",   32'(wb_src), 32'h2);
        check("t5_data",  wb_data,     32'h1234);
        check("t5_cnt",   32'(conflict_cnt), 32'd7);

        // Reset while a request is pending.
        req_valid = 4'b0001;
        tick();
        check("t6_pre_wb_en", 32'(wb_en), 32'h1);
        req_valid = 4'b0010;
        #1 check("t6_pre_ready", 32'(req_ready), 32'h2);
        rstn = 1'b0;
        #1;
        check("t6_rst_wb_en", 32'(wb_en),        32'h0);
        check("t6_rst_ready", 32'(req_ready),    32'h0);
        check("t6_rst_cnt",   32'(conflict_cnt), 32'h0);
        tick();
        check("t6_hold_wb_en", 32'(wb_en), 32'h0);
        rstn = 1'b1;
        #1 check("t6_post_ready", 32'(req_ready), 32'h2);
        tick();
        check("t6_wb_en",   32'(wb_en),   32'h1);
        check("t6_wb_src",  32'(wb_src),  32'h1);
        check("t6_wb_addr", 32'(wb_addr), 32'h5);
        req_valid = 4'b1111;
        repeat (65534) @(posedge clk);
        #1 check("t6_cnt_fffe", 32'(conflict_cnt), 32'hFFFE);
        repeat (3) @(posedge clk);
        #1 check("t6_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk);
        #1 check("t6_cnt_nowrap", 32'(conflict_cnt), 32'hFFFF);
        req_valid = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
